chicken_board_datapath: RTL and testbench
=========================================

# chicken_board_datapath

Parametrised game datapath for the Chicken Cha Cha Cha board: holds the tile-picture ring, every player's chicken position and tail count, evaluates each flipped-token guess, performs jump-and-steal, rotates turns among the active players and flags the winner. Generalises the fixed 4-player datapath to NUM_PLAYERS/NUM_TILES, a loadable board, a runtime player count and a real turn FSM with a guess handshake. Sits between the input/FSM front-end (guess source) and the display/score back-end.

## Interface
- NUM_PLAYERS, 4: maximum players (2..8); PID_W = max(1,$clog2(NUM_PLAYERS)), CNT_W = $clog2(NUM_PLAYERS+1)
- NUM_TILES, 24: ring length, must be >= 2*NUM_PLAYERS; PTR_W = $clog2(NUM_TILES)
- PIC_W, 4: tile picture id width
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- n_players  in  PID_W+1  active player count, sampled on accepted start
- start  in  1  (re)initialise game; honoured in IDLE and WIN only
- board_we / board_addr / board_data  in  1 / PTR_W / PIC_W  board tile write; honoured in IDLE and WIN only
- guess_valid  in  1  guess offered
- guess_pic  in  PIC_W  picture on flipped token
- guess_ready  out  1  high only in PLAY
- result_valid  out  1  one-cycle pulse per evaluated guess
- go  out  1  last guess matched (valid with result_valid, held until next result)
- cur_player  out  PID_W  player to move
- tile_info  out  PIC_W  picture of current target tile (combinational from registers)
- win  out  1  sticky until start/reset
- winner  out  PID_W  winning player, valid while win
- pos_flat  out  NUM_PLAYERS*PTR_W  player i position at [i*PTR_W +: PTR_W]
- tail_flat  out  NUM_PLAYERS*CNT_W  player i tails at [i*CNT_W +: CNT_W]

## Operation
- States: IDLE, PLAY, EVAL, WIN. Reset -> IDLE; all outputs, positions, tails, board cells = 0.
- Accepted start: n_eff = clamp(n_players, 2, NUM_PLAYERS); pos_i = i*(NUM_TILES/NUM_PLAYERS) for all i; tails_i = 1 for i < n_eff, else 0; cur_player = 0; win = 0; go = 0; -> PLAY.
- Occupied(t): some active player j != cur (j < n_eff) has pos_j == t.
- Target: a1 = (pos_cur+1) mod NUM_TILES. If !occupied(a1): target = a1, no victim. Else target = (pos_cur+2) mod NUM_TILES, victim = occupant of a1. tile_info = board[target].
- PLAY: guess_valid & guess_ready latches guess_pic -> EVAL.
- EVAL match (guess == board[target]) and target not occupied: pos_cur = target; if victim, tails_cur += tails_victim, tails_victim = 0; cur_player unchanged; go = 1.
- EVAL miss, or target occupied (double block): positions/tails unchanged; cur_player = (cur+1) mod n_eff; go = 0.
- After EVAL: if tails_cur == n_eff after steal -> win = 1, winner = cur, -> WIN; else -> PLAY.
- WIN: guesses ignored (guess_ready = 0); board writes and start allowed.
- All position arithmetic wraps mod NUM_TILES (no power-of-two assumption). Tail sum cannot exceed n_eff.
- start / board_we in PLAY or EVAL: ignored. Inactive players never occupy or move.

## Timing
- Guess sampled at edge E0; EVAL registers go, pos, tails, cur_player, win at E1; result_valid high for exactly the cycle after E1. Next guess acceptable that same cycle (guess_ready = 1 again).
- guess_ready low during EVAL; guess_valid there is not consumed.
- Board write: visible in tile_info the cycle after the write edge.
- Async reset in any state (including EVAL) clears immediately; no partial move committed.

## Test plan
- Reset: hold rst=0 mid-EVAL -> all outputs 0, guess_ready 0, state IDLE; release, start with n_players=4 -> pos 0/6/12/18, tails 1/1/1/1, cur_player 0.
- Match: board[t]=t[3:0], n=4, guess 1 -> result_valid 2 edges later, go=1, pos0=1, cur_player 0, tile_info 2.
- Miss: guess 9 at pos0=1 -> go=0, pos unchanged, cur_player 1; three more misses -> cur_player wraps to 0.
- Jump-and-steal: player0 matches to 5, tile_info = board[7]; guess 7 -> pos0=7, tails0=2, tails1=0.
- Win: n_players=2 (NUM_PLAYERS=4): player0 matches 1..5 then 7 stealing player1 -> win=1, winner=0, guess_ready 0, further guesses ignored; start -> fresh game.
- Wrap/clamp: n_players=7 clamps to 4; player3 advances 18..23, target skips occupied tile 0 to 1, match -> pos3=1, tails3=2, tails0=0.

Source files
------------

// File: rtl/chicken_board_datapath_if.sv
// Guess handshake between the guess source (front-end FSM) and the board datapath,
// including the one-cycle result pulse and the match flag that goes with it.
interface chicken_board_datapath_if #(
    parameter int PIC_W = 4
);
    logic             guess_valid;
    logic [PIC_W-1:0] guess_pic;
    logic             guess_ready;
    logic             result_valid;
    logic             go;

    modport master (
        output guess_valid,
        output guess_pic,
        input  guess_ready,
        input  result_valid,
        input  go
    );

    modport slave (
        input  guess_valid,
        input  guess_pic,
        output guess_ready,
        output result_valid,
        output go
    );
endinterface

// File: rtl/chicken_board_datapath.sv
// Chicken Cha Cha Cha board datapath: tile ring, chicken positions and tails,
// guess evaluation with jump-and-steal, turn rotation and win detection.
module chicken_board_datapath #(
    parameter int  NUM_PLAYERS = 4,
    parameter int  NUM_TILES   = 24,
    parameter int  PIC_W       = 4,
    localparam int PID_W       = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1,
    localparam int CNT_W       = $clog2(NUM_PLAYERS + 1),
    localparam int PTR_W       = $clog2(NUM_TILES)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [PID_W:0]               n_players,
    input  logic                         start,
    input  logic                         board_we,
    input  logic [PTR_W-1:0]             board_addr,
    input  logic [PIC_W-1:0]             board_data,
    chicken_board_datapath_if.slave      gif,
    output logic [PID_W-1:0]             cur_player,
    output logic [PIC_W-1:0]             tile_info,
    output logic                         win,
    output logic [PID_W-1:0]             winner,
    output logic [NUM_PLAYERS*PTR_W-1:0] pos_flat,
    output logic [NUM_PLAYERS*CNT_W-1:0] tail_flat
);
    localparam int SPACING = NUM_TILES / NUM_PLAYERS;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_EVAL = 2'd2,
        ST_WIN  = 2'd3
    } state_t;

    state_t           state_q;
    logic [PIC_W-1:0] board_q [NUM_TILES];
    logic [PTR_W-1:0] pos_q   [NUM_PLAYERS];
    logic [CNT_W-1:0] tails_q [NUM_PLAYERS];
    logic [PID_W-1:0] cur_q;
    logic [CNT_W-1:0] n_eff_q;
    logic [PIC_W-1:0] guess_q;
    logic             go_q;
    logic             rv_q;
    logic             win_q;
    logic [PID_W-1:0] winner_q;

    logic [PTR_W-1:0] a1_s;
    logic [PTR_W-1:0] a2_s;
    logic [PTR_W-1:0] target_s;
    logic             occ1_s;
    logic             occ2_s;
    logic [PID_W-1:0] vic_s;
    logic             match_s;
    logic [CNT_W-1:0] new_tail_d;
    logic [PID_W-1:0] next_cur_d;
    logic [CNT_W-1:0] n_eff_d;

    // Ring successor; NUM_TILES need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(NUM_TILES - 1)) begin
            return '0;
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Target tile selection, occupancy and victim lookup for the player to move.
    always_comb begin
        a1_s   = ptr_inc(pos_q[cur_q]);
        a2_s   = ptr_inc(a1_s);
        occ1_s = 1'b0;
        occ2_s = 1'b0;
        vic_s  = '0;
        for (int j = 0; j < NUM_PLAYERS; j++) begin
            logic act;
            act    = (CNT_W'(j) < n_eff_q) && (PID_W'(j) != cur_q);
            vic_s  = (act && (pos_q[j] == a1_s)) ? PID_W'(j) : vic_s;
            occ1_s = occ1_s | (act && (pos_q[j] == a1_s));
            occ2_s = occ2_s | (act && (pos_q[j] == a2_s));
        end
        target_s   = occ1_s ? a2_s : a1_s;
        match_s    = (guess_q == board_q[target_s]) && !(occ1_s && occ2_s);
        new_tail_d = tails_q[cur_q] + (occ1_s ? tails_q[vic_s] : CNT_W'(0));
        next_cur_d = ((CNT_W'(cur_q) + CNT_W'(1)) >= n_eff_q) ? PID_W'(0) : (cur_q + PID_W'(1));
    end

    // Active player count clamped into the legal 2..NUM_PLAYERS range.
    always_comb begin
        if (int'(n_players) < 2) begin
            n_eff_d = CNT_W'(2);
        end else if (int'(n_players) > NUM_PLAYERS) begin
            n_eff_d = CNT_W'(NUM_PLAYERS);
        end else begin
            n_eff_d = CNT_W'(n_players);
        end
    end

    // Turn FSM together with all board, position and score state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cur_q    <= '0;
            n_eff_q  <= '0;
            guess_q  <= '0;
            go_q     <= 1'b0;
            rv_q     <= 1'b0;
            win_q    <= 1'b0;
            winner_q <= '0;
            for (int t = 0; t < NUM_TILES; t++) begin
                board_q[t] <= '0;
            end
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                pos_q[i]   <= '0;
                tails_q[i] <= '0;
            end
        end else begin
            rv_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_WIN: begin
                    if (board_we && ({1'b0, board_addr} < (PTR_W+1)'(NUM_TILES))) begin
                        board_q[board_addr] <= board_data;
                    end
                    if (start) begin
                        state_q  <= ST_PLAY;
                        n_eff_q  <= n_eff_d;
                        cur_q    <= '0;
                        go_q     <= 1'b0;
                        win_q    <= 1'b0;
                        winner_q <= '0;
                        for (int i = 0; i < NUM_PLAYERS; i++) begin
                            pos_q[i]   <= PTR_W'(i * SPACING);
                            tails_q[i] <= (CNT_W'(i) < n_eff_d) ? CNT_W'(1) : CNT_W'(0);
                        end
                    end
                end
                ST_PLAY: begin
                    if (gif.guess_valid) begin
                        guess_q <= gif.guess_pic;
                        state_q <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    rv_q <= 1'b1;
                    if (match_s) begin
                        go_q          <= 1'b1;
                        pos_q[cur_q]  <= target_s;
                        if (occ1_s) begin
                            tails_q[vic_s] <= '0;
                        end
                        tails_q[cur_q] <= new_tail_d;
                        if (new_tail_d == n_eff_q) begin
                            win_q    <= 1'b1;
                            winner_q <= cur_q;
                            state_q  <= ST_WIN;
                        end else begin
                            state_q  <= ST_PLAY;
                        end
                    end else begin
                        go_q    <= 1'b0;
                        cur_q   <= next_cur_d;
                        state_q <= ST_PLAY;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign gif.guess_ready  = (state_q == ST_PLAY);
    assign gif.result_valid = rv_q;
    assign gif.go           = go_q;
    assign cur_player       = cur_q;
    assign tile_info        = board_q[target_s];
    assign win              = win_q;
    assign winner           = winner_q;

    for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_flat
        assign pos_flat[gi*PTR_W +: PTR_W]  = pos_q[gi];
        assign tail_flat[gi*CNT_W +: CNT_W] = tails_q[gi];
    end
endmodule

// File: tb/tb_chicken_board_datapath.sv
// Self-checking bench: directed game scenarios plus random games, all compared
// against a plain-integer model of the board rules.
module tb_chicken_board_datapath;
    localparam int NP    = 4;
    localparam int NT    = 24;
    localparam int PW    = 4;
    localparam int PID_W = $clog2(NP);
    localparam int CNT_W = $clog2(NP + 1);
    localparam int PTR_W = $clog2(NT);

    logic                  clk = 1'b0;
    logic                  rst;
    logic [PID_W:0]        n_players;
    logic                  start;
    logic                  board_we;
    logic [PTR_W-1:0]      board_addr;
    logic [PW-1:0]         board_data;
    logic [PID_W-1:0]      cur_player;
    logic [PW-1:0]         tile_info;
    logic                  win;
    logic [PID_W-1:0]      winner;
    logic [NP*PTR_W-1:0]   pos_flat;
    logic [NP*CNT_W-1:0]   tail_flat;

    chicken_board_datapath_if #(.PIC_W(PW)) gif ();

    chicken_board_datapath #(.NUM_PLAYERS(NP), .NUM_TILES(NT), .PIC_W(PW)) dut (
        .clk(clk), .rst(rst), .n_players(n_players), .start(start),
        .board_we(board_we), .board_addr(board_addr), .board_data(board_data),
        .gif(gif), .cur_player(cur_player), .tile_info(tile_info), .win(win),
        .winner(winner), .pos_flat(pos_flat), .tail_flat(tail_flat)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state
    int m_pos [NP];
    int m_tails [NP];
    int m_board [NT];
    int m_cur, m_n, m_go, m_win, m_winner, m_live;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int occupant(input int t);
        for (int j = 0; j < m_n; j++) begin
            if (j != m_cur && m_pos[j] == t) return j;
        end
        return -1;
    endfunction

    function automatic int m_target();
        int a1;
        a1 = (m_pos[m_cur] + 1) % NT;
        return (occupant(a1) < 0) ? a1 : (m_pos[m_cur] + 2) % NT;
    endfunction

    task automatic model_reset();
        for (int t = 0; t < NT; t++) m_board[t] = 0;
        for (int i = 0; i < NP; i++) begin m_pos[i] = 0; m_tails[i] = 0; end
        m_cur = 0; m_n = 0; m_go = 0; m_win = 0; m_winner = 0; m_live = 0;
    endtask

    task automatic model_start(input int n);
        m_n = (n < 2) ? 2 : ((n > NP) ? NP : n);
        for (int i = 0; i < NP; i++) begin
            m_pos[i]   = i * (NT / NP);
            m_tails[i] = (i < m_n) ? 1 : 0;
        end
        m_cur = 0; m_go = 0; m_win = 0; m_winner = 0; m_live = 1;
    endtask

    task automatic model_guess(input int pic);
        int a1, v, tgt;
        bit blocked;
        a1      = (m_pos[m_cur] + 1) % NT;
        v       = occupant(a1);
        tgt     = m_target();
        blocked = (v >= 0) && (occupant(tgt) >= 0);
        if (!blocked && pic == m_board[tgt]) begin
            m_pos[m_cur] = tgt;
            if (v >= 0) begin
                m_tails[m_cur] += m_tails[v];
                m_tails[v] = 0;
            end
            m_go = 1;
            if (m_tails[m_cur] == m_n) begin
                m_win = 1; m_winner = m_cur; m_live = 0;
            end
        end else begin
            m_go  = 0;
            m_cur = (m_cur + 1) % m_n;
        end
    endtask

    task automatic check_all(input string tag);
        logic [NP*PTR_W-1:0] ep;
        logic [NP*CNT_W-1:0] et;
        for (int i = 0; i < NP; i++) begin
            ep[i*PTR_W +: PTR_W] = PTR_W'(m_pos[i]);
            et[i*CNT_W +: CNT_W] = CNT_W'(m_tails[i]);
        end
        chk({tag, ".pos"},   64'(pos_flat),        64'(ep));
        chk({tag, ".tails"}, 64'(tail_flat),       64'(et));
        chk({tag, ".cur"},   64'(cur_player),      64'(m_cur));
        chk({tag, ".tile"},  64'(tile_info),       64'(m_board[m_target()]));
        chk({tag, ".win"},   64'(win),             64'(m_win));
        chk({tag, ".go"},    64'(gif.go),          64'(m_go));
        chk({tag, ".ready"}, 64'(gif.guess_ready), 64'(m_live));
        if (m_win != 0) chk({tag, ".winner"}, 64'(winner), 64'(m_winner));
    endtask

    task automatic write_board(input int addr, input int data);
        board_we = 1'b1; board_addr = PTR_W'(addr); board_data = PW'(data);
        @(negedge clk);
        board_we = 1'b0;
        if (m_live == 0) m_board[addr] = data;
    endtask

    task automatic do_start(input int n);
        start = 1'b1; n_players = (PID_W+1)'(n);
        @(negedge clk);
        start = 1'b0;
        if (m_live == 0) model_start(n);
    endtask

    task automatic do_guess(input int pic, input bit hold);
        int waitc = 0;
        while (gif.guess_ready !== 1'b1 && waitc < 16) begin
            @(negedge clk);
            waitc++;
        end
        if (gif.guess_ready !== 1'b1) begin
            chk("ready_timeout", 64'(gif.guess_ready), 64'd1);
            return;
        end
        gif.guess_valid = 1'b1; gif.guess_pic = PW'(pic);
        @(negedge clk);
        if (!hold) gif.guess_valid = 1'b0;
        chk("eval.ready", 64'(gif.guess_ready), 64'd0);
        chk("eval.rv",    64'(gif.result_valid), 64'd0);
        @(negedge clk);
        gif.guess_valid = 1'b0;
        model_guess(pic);
        chk("res.rv", 64'(gif.result_valid), 64'd1);
        check_all("res");
        @(negedge clk);
        chk("res.pulse", 64'(gif.result_valid), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; start = 1'b0; n_players = '0; board_we = 1'b0;
        board_addr = '0; board_data = '0;
        gif.guess_valid = 1'b0; gif.guess_pic = '0;
        model_reset();
        @(negedge clk); @(negedge clk);
        check_all("reset");
        chk("reset.rv", 64'(gif.result_valid), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int t = 0; t < NT; t++) write_board(t, t % 16);
        do_start(4);
        check_all("start4");
        chk("start4.pos",   64'(pos_flat),  64'({5'd18, 5'd12, 5'd6, 5'd0}));
        chk("start4.tails", 64'(tail_flat), 64'({3'd1, 3'd1, 3'd1, 3'd1}));

        do_guess(1, 1'b0);
        chk("match.go",   64'(gif.go),             64'd1);
        chk("match.pos0", 64'(pos_flat[0 +: PTR_W]), 64'd1);
        chk("match.tile", 64'(tile_info),          64'd2);

        do_guess(9, 1'b1);
        chk("miss.cur", 64'(cur_player), 64'd1);
        for (int k = 0; k < 3; k++) do_guess(9, 1'b0);
        chk("miss.wrap", 64'(cur_player), 64'd0);

        for (int k = 0; k < 4; k++) do_guess(m_board[m_target()], 1'b0);
        chk("jump.tile", 64'(tile_info), 64'd7);
        do_guess(7, 1'b0);
        chk("steal.pos0",   64'(pos_flat[0 +: PTR_W]),    64'd7);
        chk("steal.tails0", 64'(tail_flat[0 +: CNT_W]),   64'd2);
        chk("steal.tails1", 64'(tail_flat[CNT_W +: CNT_W]), 64'd0);

        // Asynchronous reset while a guess is being evaluated
        gif.guess_valid = 1'b1; gif.guess_pic = PW'(m_board[m_target()]);
        @(negedge clk);
        gif.guess_valid = 1'b0;
        rst = 1'b0;
        #1;
        model_reset();
        check_all("rst_eval");
        chk("rst_eval.rv", 64'(gif.result_valid), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_eval.norv", 64'(gif.result_valid), 64'd0);

        for (int t = 0; t < NT; t++) write_board(t, t % 16);
        do_start(2);
        check_all("start2");
        for (int k = 0; k < 6; k++) do_guess(m_board[m_target()], 1'b0);
        chk("win.flag",   64'(win),             64'd1);
        chk("win.winner", 64'(winner),          64'd0);
        chk("win.ready",  64'(gif.guess_ready), 64'd0);
        gif.guess_valid = 1'b1; gif.guess_pic = PW'(m_board[m_target()]);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("win.ignored", 64'(gif.result_valid), 64'd0);
        end
        gif.guess_valid = 1'b0;
        check_all("win.hold");
        write_board(8, 10);
        check_all("win.wr");

        do_start(7);
        check_all("clamp");
        chk("clamp.tails", 64'(tail_flat), 64'({3'd1, 3'd1, 3'd1, 3'd1}));
        for (int k = 0; k < 3; k++) do_guess(m_board[m_target()] ^ 1, 1'b0);
        chk("wrap.cur3", 64'(cur_player), 64'd3);
        for (int k = 0; k < 6; k++) do_guess(m_board[m_target()], 1'b0);
        chk("wrap.pos3",   64'(pos_flat[3*PTR_W +: PTR_W]),  64'd1);
        chk("wrap.tails3", 64'(tail_flat[3*CNT_W +: CNT_W]), 64'd2);
        chk("wrap.tails0", 64'(tail_flat[0 +: CNT_W]),       64'd0);

        // Random games on small picture alphabets so matches are frequent
        for (int g = 0; g < 5; g++) begin
            for (int t = 0; t < NT; t++) write_board(t, $urandom_range(0, 3));
            do_start($urandom_range(0, 7));
            check_all("rnd.start");
            for (int k = 0; k < 150 && m_live != 0; k++) begin
                if ($urandom_range(0, 9) == 0) begin
                    write_board($urandom_range(0, NT - 1), $urandom_range(0, 15));
                    do_start($urandom_range(0, 7));
                    check_all("rnd.ignored");
                end
                do_guess(($urandom_range(0, 1) != 0) ? m_board[m_target()] : $urandom_range(0, 15),
                         1'($urandom_range(0, 1)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
